// File: rtl/ysyx_23060203_csr_ctrl_pkg.sv
// ysyx_23060203_csr_ctrl_pkg
// Shared definitions for the CSR sequencing front-end: request op encodings,
// the machine-mode CSR addresses it touches, the ECALL cause code, the
// sequencer state enum and the mstatus interrupt-stack bit positions.
// The mstatus stack helper is used only when YSYX_CSR_MSTATUS_STACK_EN is set.

package ysyx_23060203_csr_ctrl_pkg;

    // Request op encodings as resolved by decode; 5..7 are reserved
    localparam logic [2:0] OP_CSRRW = 3'd0;
    localparam logic [2:0] OP_CSRRS = 3'd1;
    localparam logic [2:0] OP_CSRRC = 3'd2;
    localparam logic [2:0] OP_ECALL = 3'd3;
    localparam logic [2:0] OP_MRET  = 3'd4;

    // Machine-mode CSR addresses used by the trap sequences
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    // mcause value for an environment call from M-mode
    localparam logic [31:0] MCAUSE_ECALL = 32'd11;

    // mstatus bit positions for the interrupt-enable stack
    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_MSTAT,
        ST_RESP
    } state_t;

    // True for the three read-modify-write CSR instructions
    function automatic logic is_csr_op(input logic [2:0] op);
        return (op == OP_CSRRW) || (op == OP_CSRRS) || (op == OP_CSRRC);
    endfunction

    // New mstatus after a trap entry (ECALL) or trap return (MRET).
    // ECALL pushes MIE into MPIE and disables interrupts; MRET pops it back
    // and re-arms MPIE. Only M-mode exists, so MPP is always forced to 2'b11.
    function automatic logic [31:0] mstatus_stack(input logic [2:0] op,
                                                  input logic [31:0] old);
        logic [31:0] v;
        v = old;
        if (op == OP_ECALL) begin
            v[MSTATUS_MPIE] = old[MSTATUS_MIE];
            v[MSTATUS_MIE]  = 1'b0;
        end else begin
            v[MSTATUS_MIE]  = old[MSTATUS_MPIE];
            v[MSTATUS_MPIE] = 1'b1;
        end
        v[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        return v;
    endfunction

endpackage

// File: rtl/ysyx_23060203_csr_alu.sv
// ysyx_23060203_csr_alu
// Combinational new-value computation for CSRRW/CSRRS/CSRRC. Set/clear forms
// with a zero source field perform no write at all, so side effects of a
// write never occur for a pure read. Trap and reserved ops never write here.

module ysyx_23060203_csr_alu
    import ysyx_23060203_csr_ctrl_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] old,
    input  logic [31:0] src,
    input  logic        src_zero,
    output logic        wen,
    output logic [31:0] wdata
);

    // Select write enable and value from the op; no write by default
    always_comb begin
        wen   = 1'b0;
        wdata = 32'h0;
        case (op)
            OP_CSRRW: begin
                wen   = 1'b1;
                wdata = src;
            end
            OP_CSRRS: begin
                wen   = !src_zero;
                wdata = old | src;
            end
            OP_CSRRC: begin
                wen   = !src_zero;
                wdata = old & ~src;
            end
            default: begin
                wen   = 1'b0;
                wdata = 32'h0;
            end
        endcase
    end

endmodule

// File: rtl/ysyx_23060203_csr_ctrl.sv
// ysyx_23060203_csr_ctrl
// Sequencing front-end for the machine-mode CSR file. Takes one CSR op or trap
// event per handshake, reads the CSR file's combinational port, drives its two
// synchronous write ports and returns the old value plus any PC redirect.
// Sequence: IDLE -> READ -> WRITE -> [MSTAT] -> RESP -> IDLE.
// Optional feature macro: YSYX_CSR_MSTATUS_STACK_EN adds the MSTAT cycle in
// which ECALL/MRET update the mstatus interrupt-enable stack.

module ysyx_23060203_csr_ctrl
    import ysyx_23060203_csr_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [11:0] req_addr,
    input  logic [31:0] req_src,
    input  logic        req_src_zero,
    input  logic [31:0] req_pc,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_redirect,
    output logic [31:0] resp_target,
    output logic [11:0] csr_raddr,
    input  logic [31:0] csr_rdata,
    output logic        csr_wen1,
    output logic [11:0] csr_waddr1,
    output logic [31:0] csr_wdata1,
    output logic        csr_wen2,
    output logic [11:0] csr_waddr2,
    output logic [31:0] csr_wdata2
);

`ifdef YSYX_CSR_MSTATUS_STACK_EN
    localparam logic STACK_EN = 1'b1;
`else
    localparam logic STACK_EN = 1'b0;
`endif

    state_t      state;
    state_t      state_next;

    logic [2:0]  op_q;
    logic [11:0] addr_q;
    logic [31:0] src_q;
    logic        src_zero_q;
    logic [31:0] pc_q;
    logic [31:0] old_q;

    logic        alu_wen;
    logic [31:0] alu_wdata;
    logic        is_trap;

    assign is_trap = (op_q == OP_ECALL) || (op_q == OP_MRET);

    ysyx_23060203_csr_alu u_alu (
        .op       (op_q),
        .old      (old_q),
        .src      (src_q),
        .src_zero (src_zero_q),
        .wen      (alu_wen),
        .wdata    (alu_wdata)
    );

    // State register; reset aborts any sequence in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: fixed walk through the sequence, RESP waits for the consumer
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    state_next = ST_READ;
                end
            end
            ST_READ: begin
                state_next = ST_WRITE;
            end
            ST_WRITE: begin
                if (STACK_EN && is_trap) begin
                    state_next = ST_MSTAT;
                end else begin
                    state_next = ST_RESP;
                end
            end
            ST_MSTAT: begin
                state_next = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Capture the request only when accepted in IDLE; later req_valid is ignored
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q       <= OP_CSRRW;
            addr_q     <= 12'h0;
            src_q      <= 32'h0;
            src_zero_q <= 1'b0;
            pc_q       <= 32'h0;
        end else if (state == ST_IDLE && req_valid) begin
            op_q       <= req_op;
            addr_q     <= req_addr;
            src_q      <= req_src;
            src_zero_q <= req_src_zero;
            pc_q       <= req_pc;
        end
    end

    // Capture the CSR read value once; it feeds the ALU, rdata and the target
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            old_q <= 32'h0;
        end else if (state == ST_READ) begin
            old_q <= csr_rdata;
        end
    end

    // Read address: the op's CSR in READ, mstatus in MSTAT, zero otherwise
    always_comb begin
        csr_raddr = 12'h0;
        case (state)
            ST_READ: begin
                case (op_q)
                    OP_CSRRW, OP_CSRRS, OP_CSRRC: csr_raddr = addr_q;
                    OP_ECALL:                     csr_raddr = CSR_MTVEC;
                    OP_MRET:                      csr_raddr = CSR_MEPC;
                    default:                      csr_raddr = 12'h0;
                endcase
            end
            ST_MSTAT: begin
                csr_raddr = CSR_MSTATUS;
            end
            default: begin
                csr_raddr = 12'h0;
            end
        endcase
    end

    // Write ports: active only in WRITE/MSTAT and killed at once by reset,
    // so nothing partial is committed on the edge that sees reset high
    always_comb begin
        csr_wen1   = 1'b0;
        csr_waddr1 = 12'h0;
        csr_wdata1 = 32'h0;
        csr_wen2   = 1'b0;
        csr_waddr2 = 12'h0;
        csr_wdata2 = 32'h0;
        if (!rst) begin
            case (state)
                ST_WRITE: begin
                    if (op_q == OP_ECALL) begin
                        csr_wen1   = 1'b1;
                        csr_waddr1 = CSR_MEPC;
                        csr_wdata1 = pc_q;
                        csr_wen2   = 1'b1;
                        csr_waddr2 = CSR_MCAUSE;
                        csr_wdata2 = MCAUSE_ECALL;
                    end else if (alu_wen) begin
                        csr_wen1   = 1'b1;
                        csr_waddr1 = addr_q;
                        csr_wdata1 = alu_wdata;
                    end
                end
                ST_MSTAT: begin
                    csr_wen1   = 1'b1;
                    csr_waddr1 = CSR_MSTATUS;
                    csr_wdata1 = mstatus_stack(op_q, csr_rdata);
                end
                default: begin
                    csr_wen1 = 1'b0;
                    csr_wen2 = 1'b0;
                end
            endcase
        end
    end

    // Response fields are shown only in RESP and held there while stalled
    always_comb begin
        req_ready     = (state == ST_IDLE);
        resp_valid    = 1'b0;
        resp_rdata    = 32'h0;
        resp_redirect = 1'b0;
        resp_target   = 32'h0;
        if (state == ST_RESP) begin
            resp_valid = 1'b1;
            if (is_csr_op(op_q)) begin
                resp_rdata = old_q;
            end
            if (op_q == OP_ECALL) begin
                resp_redirect = 1'b1;
                resp_target   = {old_q[31:2], 2'b00};
            end else if (op_q == OP_MRET) begin
                resp_redirect = 1'b1;
                resp_target   = old_q;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_23060203_csr_ctrl.sv
// tb_ysyx_23060203_csr_ctrl
// Self-checking bench for the CSR sequencer. A bench-side CSR file follows
// the DUT's write ports; a separate reference copy is updated from the
// architectural rules of each op. Directed cases come first, then random ops.
// Honours YSYX_CSR_MSTATUS_STACK_EN the same way as the design.

module tb_ysyx_23060203_csr_ctrl;

`ifdef YSYX_CSR_MSTATUS_STACK_EN
    localparam bit stackEn = 1'b1;
`else
    localparam bit stackEn = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [11:0] req_addr;
    logic [31:0] req_src;
    logic        req_src_zero;
    logic [31:0] req_pc;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_redirect;
    logic [31:0] resp_target;
    logic [11:0] csr_raddr;
    logic [31:0] csr_rdata;
    logic        csr_wen1;
    logic [11:0] csr_waddr1;
    logic [31:0] csr_wdata1;
    logic        csr_wen2;
    logic [11:0] csr_waddr2;
    logic [31:0] csr_wdata2;

    logic [31:0] csrFile [4096];
    logic [31:0] refFile [4096];
    logic        presetEn;
    logic [11:0] presetAddr;
    logic [31:0] presetData;

    int checks;
    int failures;

    ysyx_23060203_csr_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .req_addr      (req_addr),
        .req_src       (req_src),
        .req_src_zero  (req_src_zero),
        .req_pc        (req_pc),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_rdata    (resp_rdata),
        .resp_redirect (resp_redirect),
        .resp_target   (resp_target),
        .csr_raddr     (csr_raddr),
        .csr_rdata     (csr_rdata),
        .csr_wen1      (csr_wen1),
        .csr_waddr1    (csr_waddr1),
        .csr_wdata1    (csr_wdata1),
        .csr_wen2      (csr_wen2),
        .csr_waddr2    (csr_waddr2),
        .csr_wdata2    (csr_wdata2)
    );

    // Free-running clock, 10 time units per cycle
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bench CSR file: combinational read, synchronous writes from the DUT
    assign csr_rdata = csrFile[csr_raddr];

    // Commit DUT writes and bench presets into the bench CSR file
    always @(posedge clk) begin
        if (presetEn) csrFile[presetAddr] <= presetData;
        if (csr_wen1) csrFile[csr_waddr1] <= csr_wdata1;
        if (csr_wen2) csrFile[csr_waddr2] <= csr_wdata2;
    end

    // Count one comparison and report it if it differs
    task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Load a CSR into both the bench file and the reference copy
    task automatic presetCsr(input logic [11:0] addr, input logic [31:0] data);
        presetEn   = 1'b1;
        presetAddr = addr;
        presetData = data;
        refFile[addr] = data;
        @(posedge clk);
        @(negedge clk);
        presetEn = 1'b0;
    endtask

    // Check both write ports against the expected writes for this cycle
    task automatic checkWrites(input string tag,
                               input bit e1, input logic [11:0] a1, input logic [31:0] d1,
                               input bit e2, input logic [11:0] a2, input logic [31:0] d2);
        checkOutput({tag, "_wen1"}, 64'(csr_wen1), 64'(e1));
        if (e1) begin
            checkOutput({tag, "_waddr1"}, 64'(csr_waddr1), 64'(a1));
            checkOutput({tag, "_wdata1"}, 64'(csr_wdata1), 64'(d1));
        end
        checkOutput({tag, "_wen2"}, 64'(csr_wen2), 64'(e2));
        if (e2) begin
            checkOutput({tag, "_waddr2"}, 64'(csr_waddr2), 64'(a2));
            checkOutput({tag, "_wdata2"}, 64'(csr_wdata2), 64'(d2));
        end
    endtask

    // Architectural mstatus interrupt-stack update, written as bit arithmetic
    function automatic logic [31:0] refMstatus(input logic [2:0] op, input logic [31:0] old);
        logic [31:0] cleared;
        cleared = old & ~32'h0000_1888;
        if (op == 3'd3) return cleared | (((old >> 3) & 32'h1) << 7) | 32'h0000_1800;
        return cleared | (((old >> 7) & 32'h1) << 3) | 32'h0000_0080 | 32'h0000_1800;
    endfunction

    // Run one request through the whole sequence, holding RESP for holdCycles
    task automatic applyStimulus(input logic [2:0] op, input logic [11:0] addr,
                                 input logic [31:0] src, input bit srcZero,
                                 input logic [31:0] pc, input int holdCycles);
        logic [31:0] old, expRdata, expTarget, w1d, w2d, msNew;
        logic [11:0] w1a, w2a;
        bit          expRedir, w1e, w2e, useMstat;

        // Reference behaviour of this op
        expRdata = 0; expTarget = 0; expRedir = 0;
        w1e = 0; w1a = 0; w1d = 0; w2e = 0; w2a = 0; w2d = 0;
        old = refFile[addr];
        case (op)
            3'd0: begin expRdata = old; w1e = 1; w1a = addr; w1d = src; end
            3'd1: begin expRdata = old; w1e = !srcZero; w1a = addr; w1d = old | src; end
            3'd2: begin expRdata = old; w1e = !srcZero; w1a = addr; w1d = old & ~src; end
            3'd3: begin
                expRedir = 1; expTarget = refFile[12'h305] & ~32'h3;
                w1e = 1; w1a = 12'h341; w1d = pc;
                w2e = 1; w2a = 12'h342; w2d = 32'd11;
            end
            3'd4: begin expRedir = 1; expTarget = refFile[12'h341]; end
            default: ;
        endcase
        if (w1e) refFile[w1a] = w1d;
        if (w2e) refFile[w2a] = w2d;
        useMstat = stackEn && (op == 3'd3 || op == 3'd4);
        msNew = refMstatus(op, refFile[12'h300]);
        if (useMstat) refFile[12'h300] = msNew;

        checkOutput("idleReady", 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_op = op; req_addr = addr;
        req_src = src; req_src_zero = srcZero; req_pc = pc;
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_op = 3'($urandom); req_addr = 12'($urandom); req_src = $urandom; req_pc = $urandom;

        checkOutput("readReady", 64'(req_ready), 64'd0);
        checkOutput("readValid", 64'(resp_valid), 64'd0);
        checkWrites("read", 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        @(negedge clk);

        checkOutput("writeValid", 64'(resp_valid), 64'd0);
        checkWrites("write", w1e, w1a, w1d, w2e, w2a, w2d);
        @(posedge clk);
        @(negedge clk);

        if (useMstat) begin
            checkOutput("mstatValid", 64'(resp_valid), 64'd0);
            checkWrites("mstat", 1, 12'h300, msNew, 0, 0, 0);
            @(posedge clk);
            @(negedge clk);
        end

        if (holdCycles > 0) resp_ready = 1'b0;
        for (int h = 0; h <= holdCycles; h++) begin
            checkOutput("respValid", 64'(resp_valid), 64'd1);
            checkOutput("respReady", 64'(req_ready), 64'd0);
            checkOutput("respRdata", 64'(resp_rdata), 64'(expRdata));
            checkOutput("respRedirect", 64'(resp_redirect), 64'(expRedir));
            checkOutput("respTarget", 64'(resp_target), 64'(expTarget));
            checkWrites("resp", 0, 0, 0, 0, 0, 0);
            if (h < holdCycles) begin
                req_valid = 1'b1;
                req_op = 3'($urandom); req_addr = 12'($urandom); req_src = $urandom;
                @(posedge clk);
                @(negedge clk);
            end
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("backIdleReady", 64'(req_ready), 64'd1);
        checkOutput("backIdleValid", 64'(resp_valid), 64'd0);
    endtask

    // Pulse reset in the WRITE cycle of an ECALL; nothing may be committed
    task automatic resetDuringEcall();
        presetCsr(12'h341, 32'h1111_1111);
        presetCsr(12'h342, 32'h2222_2222);
        req_valid = 1'b1; req_op = 3'd3; req_pc = 32'h8000_0080;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("preRstWen1", 64'(csr_wen1), 64'd1);
        rst = 1'b1;
        #1;
        checkOutput("rstWen1", 64'(csr_wen1), 64'd0);
        checkOutput("rstWen2", 64'(csr_wen2), 64'd0);
        checkOutput("rstReady", 64'(req_ready), 64'd1);
        checkOutput("rstValid", 64'(resp_valid), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("postRstValid", 64'(resp_valid), 64'd0);
            checkOutput("postRstReady", 64'(req_ready), 64'd1);
        end
        checkOutput("rstMepcKept", 64'(csrFile[12'h341]), 64'(refFile[12'h341]));
        checkOutput("rstMcauseKept", 64'(csrFile[12'h342]), 64'(refFile[12'h342]));
    endtask

    logic [11:0] addrPool [5];

    initial begin
        checks = 0;
        failures = 0;
        addrPool[0] = 12'h300; addrPool[1] = 12'h305; addrPool[2] = 12'h341;
        addrPool[3] = 12'h342; addrPool[4] = 12'h340;
        rst = 1'b1;
        req_valid = 1'b0; req_op = 3'd0; req_addr = 12'h0; req_src = 32'h0;
        req_src_zero = 1'b0; req_pc = 32'h0; resp_ready = 1'b1;
        presetEn = 1'b0; presetAddr = 12'h0; presetData = 32'h0;
        #1;
        checkOutput("rstReqReady", 64'(req_ready), 64'd1);
        checkOutput("rstRespValid", 64'(resp_valid), 64'd0);
        checkOutput("rstRedirect", 64'(resp_redirect), 64'd0);
        checkOutput("rstRdata", 64'(resp_rdata), 64'd0);
        checkOutput("rstTarget", 64'(resp_target), 64'd0);
        checkOutput("rstRaddr", 64'(csr_raddr), 64'd0);
        checkWrites("rst", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        presetCsr(12'h000, 32'h0);
        for (int i = 0; i < 5; i++) presetCsr(addrPool[i], 32'h0);

        // Directed cases
        applyStimulus(3'd0, 12'h305, 32'h8000_0100, 1'b0, 32'h0, 0);
        presetCsr(12'h300, 32'h0000_1800);
        applyStimulus(3'd1, 12'h300, 32'h0000_0008, 1'b0, 32'h0, 0);
        applyStimulus(3'd1, 12'h300, 32'h0000_0000, 1'b1, 32'h0, 0);
        applyStimulus(3'd2, 12'h300, 32'h0000_0000, 1'b1, 32'h0, 0);
        presetCsr(12'h305, 32'h8000_0103);
        applyStimulus(3'd3, 12'h000, 32'h0, 1'b0, 32'h8000_0040, 0);
        presetCsr(12'h341, 32'h8000_0044);
        presetCsr(12'h300, 32'h0000_1880);
        applyStimulus(3'd4, 12'h000, 32'h0, 1'b0, 32'h0, 0);
        applyStimulus(3'd2, 12'h342, 32'h0000_00F0, 1'b0, 32'h0, 5);
        applyStimulus(3'd6, 12'h305, 32'hFFFF_FFFF, 1'b0, 32'h1234_5678, 2);
        resetDuringEcall();

        // Random ops checked against the reference copy
        for (int n = 0; n < 60; n++) begin
            logic [2:0]  rop;
            logic [11:0] raddr;
            logic [31:0] rsrc;
            bit          rzero;
            rop   = 3'($urandom_range(0, 7));
            raddr = addrPool[$urandom_range(0, 4)];
            rzero = ($urandom_range(0, 3) == 0);
            rsrc  = rzero ? 32'h0 : (($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 31)) : $urandom);
            if (rzero == 0 && rsrc == 0) rsrc = 32'h1;
            applyStimulus(rop, raddr, rsrc, rzero, {$urandom} & ~32'h3, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0);
        end

        for (int i = 0; i < 5; i++) begin
            checkOutput("finalFile", 64'(csrFile[addrPool[i]]), 64'(refFile[addrPool[i]]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
